iob_arbiter2: RTL and testbench

Two-master, one-slave IOb bus arbiter for the Caravel user area. It lets the Wishbone-to-IOb bridge (management SoC path) and a second IOb requester, such as a logic-analyzer debug port or a DMA engine, share one IOb slave port, normally the SoC memory or peripheral bus. Grants use round-robin, and only one transaction is outstanding at a time. A read-response timeout ensures a silent slave can never hang the Wishbone side.

---
 rtl/iob_arbiter2.sv | 152 +++++++++++++++
 tb/tb_iob_arbiter2.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_arbiter2.sv
// Two-master, one-slave IOb arbiter with round-robin grant, a single outstanding
// transaction and a read-response timeout that answers with ERR_DATA.
module iob_arbiter2 #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cke_i,

    input  logic                  m0_iob_valid_i,
    input  logic [ADDR_W-1:0]     m0_iob_address_i,
    input  logic [DATA_W-1:0]     m0_iob_wdata_i,
    input  logic [DATA_W/8-1:0]   m0_iob_wstrb_i,
    output logic                  m0_iob_ready_o,
    output logic                  m0_iob_rvalid_o,
    output logic [DATA_W-1:0]     m0_iob_rdata_o,

    input  logic                  m1_iob_valid_i,
    input  logic [ADDR_W-1:0]     m1_iob_address_i,
    input  logic [DATA_W-1:0]     m1_iob_wdata_i,
    input  logic [DATA_W/8-1:0]   m1_iob_wstrb_i,
    output logic                  m1_iob_ready_o,
    output logic                  m1_iob_rvalid_o,
    output logic [DATA_W-1:0]     m1_iob_rdata_o,

    output logic                  s_iob_valid_o,
    output logic [ADDR_W-1:0]     s_iob_address_o,
    output logic [DATA_W-1:0]     s_iob_wdata_o,
    output logic [DATA_W/8-1:0]   s_iob_wstrb_o,
    input  logic                  s_iob_ready_i,
    input  logic                  s_iob_rvalid_i,
    input  logic [DATA_W-1:0]     s_iob_rdata_i,

    output logic                  timeout_o
);

    localparam int                CNT_W    = 16;
    localparam int                STRB_W   = DATA_W / 8;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q,  last_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic               owner_valid;
    logic [STRB_W-1:0]  owner_wstrb;
    logic               rsp_valid;
    logic [DATA_W-1:0]  rsp_data;

    // last resets to 1 so that m0 wins the first tie after reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign owner_valid = owner_q ? m1_iob_valid_i : m0_iob_valid_i;
    assign owner_wstrb = owner_q ? m1_iob_wstrb_i : m0_iob_wstrb_i;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_d          = last_q;
        cnt_d           = cnt_q;
        s_iob_valid_o   = 1'b0;
        s_iob_address_o = '0;
        s_iob_wdata_o   = '0;
        s_iob_wstrb_o   = '0;
        m0_iob_ready_o  = 1'b0;
        m1_iob_ready_o  = 1'b0;
        rsp_valid       = 1'b0;
        rsp_data        = '0;
        timeout_o       = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_iob_valid_i && m1_iob_valid_i) begin
                    owner_d = ~last_q;
                    state_d = REQ;
                end else if (m0_iob_valid_i) begin
                    owner_d = 1'b0;
                    state_d = REQ;
                end else if (m1_iob_valid_i) begin
                    owner_d = 1'b1;
                    state_d = REQ;
                end
            end

            REQ: begin
                s_iob_valid_o   = owner_valid;
                s_iob_address_o = owner_q ? m1_iob_address_i : m0_iob_address_i;
                s_iob_wdata_o   = owner_q ? m1_iob_wdata_i   : m0_iob_wdata_i;
                s_iob_wstrb_o   = owner_wstrb;
                m0_iob_ready_o  = ~owner_q & s_iob_ready_i;
                m1_iob_ready_o  =  owner_q & s_iob_ready_i;
                if (owner_valid && s_iob_ready_i) begin
                    last_d  = owner_q;
                    cnt_d   = '0;
                    state_d = (owner_wstrb == '0) ? RESP : IDLE;
                end else if (!owner_valid) begin
                    state_d = IDLE;
                end
            end

            RESP: begin
                cnt_d = cnt_q + 16'd1;
                if (s_iob_rvalid_i) begin
                    rsp_valid = 1'b1;
                    rsp_data  = s_iob_rdata_i;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid = 1'b1;
                    rsp_data  = ERR_WORD;
                    timeout_o = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Only the owner ever sees rvalid; idle rdata lines are held at zero
    assign m0_iob_rvalid_o = rsp_valid & ~owner_q;
    assign m1_iob_rvalid_o = rsp_valid &  owner_q;
    assign m0_iob_rdata_o  = m0_iob_rvalid_o ? rsp_data : '0;
    assign m1_iob_rdata_o  = m1_iob_rvalid_o ? rsp_data : '0;

endmodule

// File: tb/tb_iob_arbiter2.sv
// Bench for iob_arbiter2: directed vector table, a round-robin sequence and
// randomized traffic compared against a transaction-level reference model.
module tb_iob_arbiter2;

    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, cke, v0, v1;
        logic [3:0]  ws0, ws1;
        logic [31:0] a0, a1, d0, d1;
        logic        sr, srv;
        logic [31:0] srd;
    } in_t;

    typedef struct packed {
        logic        r0, r1, rv0, rv1;
        logic [31:0] rd0, rd1;
        logic        sv;
        logic [31:0] sa, sd;
        logic [3:0]  sw;
        logic        to;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } rec_t;

    in_t  cur = '0;
    rec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    // reference model: which master holds the bus, whether it is still offering
    // its request or waiting for read data, and how long it has waited
    int m_phase = 0;
    int m_owner = 0;
    int m_last  = 1;
    int m_wait  = 0;

    logic        m0_ready, m0_rvalid, m1_ready, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, timeout;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    iob_arbiter2 #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk_i(clk), .rst_i(cur.rst), .cke_i(cur.cke),
        .m0_iob_valid_i(cur.v0), .m0_iob_address_i(cur.a0),
        .m0_iob_wdata_i(cur.d0), .m0_iob_wstrb_i(cur.ws0),
        .m0_iob_ready_o(m0_ready), .m0_iob_rvalid_o(m0_rvalid), .m0_iob_rdata_o(m0_rdata),
        .m1_iob_valid_i(cur.v1), .m1_iob_address_i(cur.a1),
        .m1_iob_wdata_i(cur.d1), .m1_iob_wstrb_i(cur.ws1),
        .m1_iob_ready_o(m1_ready), .m1_iob_rvalid_o(m1_rvalid), .m1_iob_rdata_o(m1_rdata),
        .s_iob_valid_o(s_valid), .s_iob_address_o(s_addr),
        .s_iob_wdata_o(s_wdata), .s_iob_wstrb_o(s_wstrb),
        .s_iob_ready_i(cur.sr), .s_iob_rvalid_i(cur.srv), .s_iob_rdata_i(cur.srd),
        .timeout_o(timeout)
    );

    function automatic in_t inp(bit rst, bit cke, bit v0, bit v1, logic [3:0] ws0,
                                logic [3:0] ws1, bit sr, bit srv, logic [31:0] srd);
        in_t x;
        x.rst = rst; x.cke = cke; x.v0 = v0; x.v1 = v1;
        x.ws0 = ws0; x.ws1 = ws1;
        x.a0  = 32'h10; x.d0 = 32'hA5A5A5A5;
        x.a1  = 32'h20; x.d1 = 32'h5A5A5A5A;
        x.sr  = sr; x.srv = srv; x.srd = srd;
        return x;
    endfunction

    function automatic exp_t ez();
        return '0;
    endfunction

    function automatic exp_t ereq(bit own, logic [3:0] ws, bit rdy);
        exp_t e = '0;
        e.sv = 1'b1;
        e.sa = own ? 32'h20 : 32'h10;
        e.sd = own ? 32'h5A5A5A5A : 32'hA5A5A5A5;
        e.sw = ws;
        if (own) e.r1 = rdy; else e.r0 = rdy;
        return e;
    endfunction

    function automatic exp_t ersp(bit own, logic [31:0] d, bit to);
        exp_t e = '0;
        if (own) begin e.rv1 = 1'b1; e.rd1 = d; end
        else     begin e.rv0 = 1'b1; e.rd0 = d; end
        e.to = to;
        return e;
    endfunction

    function automatic void add(in_t i, exp_t e);
        rec_t r;
        r.i = i;
        r.e = e;
        tbl.push_back(r);
    endfunction

    function automatic exp_t model_out(in_t x);
        exp_t        e = '0;
        bit          give = 0;
        logic [31:0] data = '0;
        if (m_phase == 1) begin
            e.sv = (m_owner == 1) ? x.v1  : x.v0;
            e.sa = (m_owner == 1) ? x.a1  : x.a0;
            e.sd = (m_owner == 1) ? x.d1  : x.d0;
            e.sw = (m_owner == 1) ? x.ws1 : x.ws0;
            if (m_owner == 1) e.r1 = x.sr; else e.r0 = x.sr;
        end else if (m_phase == 2) begin
            if (x.srv) begin
                give = 1; data = x.srd;
            end else if (m_wait + 1 == TO) begin
                give = 1; data = 32'hDEADBEEF; e.to = 1'b1;
            end
            if (give) begin
                if (m_owner == 1) begin e.rv1 = 1'b1; e.rd1 = data; end
                else              begin e.rv0 = 1'b1; e.rd0 = data; end
            end
        end
        return e;
    endfunction

    function automatic void model_step(in_t x);
        bit         ov;
        logic [3:0] ow;
        if (x.rst) begin
            m_phase = 0; m_owner = 0; m_last = 1; m_wait = 0;
            return;
        end
        if (!x.cke) return;
        case (m_phase)
            0: if (x.v0 || x.v1) begin
                m_owner = (x.v0 && x.v1) ? 1 - m_last : (x.v1 ? 1 : 0);
                m_phase = 1;
            end
            1: begin
                ov = (m_owner == 1) ? x.v1  : x.v0;
                ow = (m_owner == 1) ? x.ws1 : x.ws0;
                if (ov && x.sr) begin
                    m_last  = m_owner;
                    m_wait  = 0;
                    m_phase = (ow == 4'h0) ? 2 : 0;
                end else if (!ov) begin
                    m_phase = 0;
                end
            end
            default: begin
                if (x.srv || m_wait + 1 == TO) begin
                    m_phase = 0; m_wait = 0;
                end else begin
                    m_wait = m_wait + 1;
                end
            end
        endcase
    endfunction

    function automatic exp_t actual();
        exp_t g;
        g.r0 = m0_ready;  g.r1 = m1_ready;
        g.rv0 = m0_rvalid; g.rv1 = m1_rvalid;
        g.rd0 = m0_rdata;  g.rd1 = m1_rdata;
        g.sv = s_valid; g.sa = s_addr; g.sd = s_wdata; g.sw = s_wstrb;
        g.to = timeout;
        return g;
    endfunction

    task automatic applyStimulus(input in_t x);
        @(negedge clk);
        cur = x;
        #1;
    endtask

    task automatic checkOutput(input string nm, input exp_t want);
        exp_t got = actual();
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic runCycle(input string nm, input in_t x, input bit use_model, input exp_t want);
        exp_t w = use_model ? model_out(x) : want;
        applyStimulus(x);
        checkOutput(nm, w);
        model_step(x);
    endtask

    initial begin
        in_t x;

        // single write from m0
        add(inp(0,1,1,0,4'hF,4'h0,1,0,0), ez());
        add(inp(0,1,1,0,4'hF,4'h0,1,0,0), ereq(0,4'hF,1));
        add(inp(0,1,0,0,4'h0,4'h0,1,0,0), ez());
        // single read from m1, response two cycles after acceptance, then a stray rvalid
        add(inp(0,1,0,1,4'h0,4'h0,1,0,0), ez());
        add(inp(0,1,0,1,4'h0,4'h0,1,0,0), ereq(1,4'h0,1));
        add(inp(0,1,0,0,4'h0,4'h0,1,0,0), ez());
        add(inp(0,1,0,0,4'h0,4'h0,1,1,32'h12345678), ersp(1,32'h12345678,0));
        add(inp(0,1,0,0,4'h0,4'h0,1,1,32'hCAFEF00D), ez());
        // timeout on an m0 read, then m1 is served normally
        add(inp(0,1,1,0,4'h0,4'h0,1,0,0), ez());
        add(inp(0,1,1,0,4'h0,4'h0,1,0,0), ereq(0,4'h0,1));
        for (int k = 0; k < TO - 1; k++) add(inp(0,1,0,0,4'h0,4'h0,1,0,0), ez());
        add(inp(0,1,0,0,4'h0,4'h0,1,0,0), ersp(0,32'hDEADBEEF,1));
        add(inp(0,1,0,1,4'h0,4'hF,1,0,0), ez());
        add(inp(0,1,0,1,4'h0,4'hF,1,0,0), ereq(1,4'hF,1));
        // backpressure then reset while in REQ; m0 wins the first post-reset tie
        add(inp(0,1,1,0,4'h0,4'h0,0,0,0), ez());
        add(inp(0,1,1,0,4'h0,4'h0,0,0,0), ereq(0,4'h0,0));
        add(inp(1,1,1,0,4'h0,4'h0,0,0,0), ereq(0,4'h0,0));
        add(inp(0,1,0,0,4'h0,4'h0,0,1,32'h11111111), ez());
        add(inp(0,1,1,1,4'hF,4'hF,1,0,0), ez());
        add(inp(0,1,1,1,4'hF,4'hF,1,0,0), ereq(0,4'hF,1));
        add(inp(0,1,1,1,4'hF,4'hF,1,0,0), ez());
        add(inp(0,1,1,1,4'hF,4'hF,1,0,0), ereq(1,4'hF,1));
        add(inp(0,1,0,0,4'h0,4'h0,1,0,0), ez());
        // clock enable low while the request waits for slave ready
        add(inp(0,1,0,1,4'h0,4'hF,0,0,0), ez());
        for (int k = 0; k < 3; k++) add(inp(0,0,0,1,4'h0,4'hF,0,0,0), ereq(1,4'hF,0));
        add(inp(0,1,0,1,4'h0,4'hF,1,0,0), ereq(1,4'hF,1));
        add(inp(0,1,0,0,4'h0,4'h0,1,0,0), ez());
        // clock enable low during RESP delays the timeout by two cycles
        add(inp(0,1,1,0,4'h0,4'h0,1,0,0), ez());
        add(inp(0,1,1,0,4'h0,4'h0,1,0,0), ereq(0,4'h0,1));
        add(inp(0,1,0,0,4'h0,4'h0,1,0,0), ez());
        add(inp(0,0,0,0,4'h0,4'h0,1,0,0), ez());
        add(inp(0,0,0,0,4'h0,4'h0,1,0,0), ez());
        add(inp(0,1,0,0,4'h0,4'h0,1,0,0), ez());
        add(inp(0,1,0,0,4'h0,4'h0,1,0,0), ez());
        add(inp(0,1,0,0,4'h0,4'h0,1,0,0), ersp(0,32'hDEADBEEF,1));
        add(inp(0,1,0,0,4'h0,4'h0,1,0,0), ez());

        applyStimulus(inp(1,1,0,0,4'h0,4'h0,0,0,0));
        model_step(cur);
        applyStimulus(inp(1,1,0,0,4'h0,4'h0,0,0,0));
        model_step(cur);

        foreach (tbl[k]) runCycle($sformatf("vec%0d", k), tbl[k].i, 1'b0, tbl[k].e);

        // round-robin: eight back-to-back writes from both masters after reset
        runCycle("rr_reset", inp(1,1,0,0,4'h0,4'h0,0,0,0), 1'b0, ez());
        for (int k = 0; k < 8; k++) begin
            runCycle($sformatf("rr%0d_idle", k), inp(0,1,1,1,4'hF,4'hF,1,0,0), 1'b0, ez());
            runCycle($sformatf("rr%0d_grant", k), inp(0,1,1,1,4'hF,4'hF,1,0,0), 1'b0,
                     ereq(k[0], 4'hF, 1));
        end

        for (int n = 0; n < 3000; n++) begin
            x.rst = ($urandom_range(0, 99) == 0);
            x.cke = ($urandom_range(0, 7) != 0);
            x.v0  = $urandom_range(0, 1) == 1;
            x.v1  = $urandom_range(0, 1) == 1;
            x.ws0 = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            x.ws1 = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            x.a0  = $urandom; x.a1 = $urandom;
            x.d0  = $urandom; x.d1 = $urandom;
            x.sr  = $urandom_range(0, 1) == 1;
            x.srv = ($urandom_range(0, 3) == 0);
            x.srd = $urandom;
            runCycle($sformatf("rand%0d", n), x, 1'b1, ez());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
